// File: rtl/bus_pkg.sv
// Shared types and constants for the 8088 bus-cycle front end.
// Optional watchdog in bus_cycle_frontend is enabled by BUS_TIMEOUT_EN.
package bus_pkg;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_LATCH    = 5'b00010,
        ST_ARMED    = 5'b00100,
        ST_WAIT     = 5'b01000,
        ST_COMPLETE = 5'b10000
    } state_t;

    typedef enum logic {
        CYC_MEM = 1'b0,
        CYC_IO  = 1'b1
    } cyc_t;

    typedef struct packed {
        logic io1;
        logic io0;
        logic mem1;
        logic mem0;
    } cs_t;

    localparam int MEM_SPLIT_BIT = 19;
    localparam int IO_WIN_BITS   = 4;

endpackage

// File: rtl/bus_addr_decode.sv
// Address + IO/M to chip-select decode; addr excludes the in-window offset bits.
// At most one select is high; mapped flags any hit.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter logic [15:0] IO0_BASE = 16'h00F0,
    parameter logic [15:0] IO1_BASE = 16'h00E0
) (
    input  logic [19:IO_WIN_BITS] addr,
    input  logic                  iom,
    output cs_t                   cs,
    output logic                  mapped
);

    always_comb begin
        cs = '0;
        if (cyc_t'(iom) == CYC_MEM) begin
            if (addr[MEM_SPLIT_BIT]) cs.mem1 = 1'b1;
            else                     cs.mem0 = 1'b1;
        end else if (addr[19:16] == 4'h0) begin
            // IO0 is tested first so it wins when both bases coincide
            if (addr[15:IO_WIN_BITS] == IO0_BASE[15:IO_WIN_BITS])
                cs.io0 = 1'b1;
            else if (addr[15:IO_WIN_BITS] == IO1_BASE[15:IO_WIN_BITS])
                cs.io1 = 1'b1;
        end
        mapped = |cs;
    end

endmodule

// File: rtl/bus_cycle_frontend.sv
// 8088 bus front end: address latch, chip-select decode, ALE re-time, READY wait states.
// Define BUS_TIMEOUT_EN to add the ARMED-state watchdog driving BUS_ERR.
module bus_cycle_frontend
    import bus_pkg::*;
#(
    parameter int          WAIT_STATES    = 1,
    parameter logic [15:0] IO0_BASE       = 16'h00F0,
    parameter logic [15:0] IO1_BASE       = 16'h00E0,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALE,
    input  logic        IOM,
    input  logic        RD,
    input  logic        WR,
    input  logic [7:0]  AD,
    input  logic [11:0] A,
    output logic [19:0] ADDR_Q,
    output logic        IOM_Q,
    output logic        ALE_Q,
    output logic        CS_MEM0,
    output logic        CS_MEM1,
    output logic        CS_IO0,
    output logic        CS_IO1,
    output logic        READY,
    output logic        BUS_ERR
);

    localparam logic [3:0] WS_LOAD =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    state_t      state;
    logic [3:0]  cnt;
    cs_t         cs_q;
    cs_t         dec_cs;
    logic        dec_mapped;
    logic        strobe;
    logic [19:0] bus_addr;

    assign strobe   = !RD || !WR;
    assign bus_addr = {A, AD};

    // Decode the address being latched so CS lines up with ALE_Q
    bus_addr_decode #(
        .IO0_BASE (IO0_BASE),
        .IO1_BASE (IO1_BASE)
    ) u_decode (
        .addr   (bus_addr[19:IO_WIN_BITS]),
        .iom    (IOM),
        .cs     (dec_cs),
        .mapped (dec_mapped)
    );

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          err_q;
    assign BUS_ERR = err_q;
`else
    assign BUS_ERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            cs_q   <= '0;
            ADDR_Q <= '0;
            IOM_Q  <= 1'b0;
            ALE_Q  <= 1'b0;
            READY  <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            tcnt   <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            ALE_Q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (ALE) begin
                        ADDR_Q <= bus_addr;
                        IOM_Q  <= IOM;
                        ALE_Q  <= 1'b1;
                        cs_q   <= dec_mapped ? dec_cs : '0;
                        state  <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    state <= ST_ARMED;
`ifdef BUS_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                ST_ARMED: begin
                    if (strobe) begin
                        // Unmapped cycles complete with no wait states
                        if (NO_WAIT || cs_q == '0) begin
                            state <= ST_COMPLETE;
                        end else begin
                            cnt   <= WS_LOAD;
                            READY <= 1'b0;
                            state <= ST_WAIT;
                        end
                    end else if (ALE) begin
                        ADDR_Q <= bus_addr;
                        IOM_Q  <= IOM;
                        ALE_Q  <= 1'b1;
                        cs_q   <= dec_mapped ? dec_cs : '0;
                        state  <= ST_LATCH;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        cs_q  <= '0;
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        READY <= 1'b1;
                        state <= ST_COMPLETE;
                    end
                end
                ST_COMPLETE: begin
                    if (RD && WR) begin
                        cs_q  <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign CS_MEM0 = cs_q.mem0;
    assign CS_MEM1 = cs_q.mem1;
    assign CS_IO0  = cs_q.io0;
    assign CS_IO1  = cs_q.io1;

endmodule

// File: tb/tb_bus_cycle_frontend.sv
// Bench for bus_cycle_frontend: two instances (1 and 3 wait states) checked
// every cycle against a bus-cycle model, plus directed literal expectations.
module tb_bus_cycle_frontend;

    logic        CLK = 1'b0;
    logic        RESET, ALE, IOM, RD, WR;
    logic [7:0]  AD;
    logic [11:0] A;

    logic [1:0][19:0] addr_q;
    logic [1:0]       iom_q, ale_q, ready, bus_err;
    logic [1:0][3:0]  cs_o;

    int checks = 0;
    int failures = 0;
    bit started = 0;

    always #5 CLK = ~CLK;

    bus_cycle_frontend #(.WAIT_STATES(1), .TIMEOUT_CYCLES(8)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR),
        .AD(AD), .A(A), .ADDR_Q(addr_q[0]), .IOM_Q(iom_q[0]),
        .ALE_Q(ale_q[0]), .CS_MEM0(cs_o[0][0]), .CS_MEM1(cs_o[0][1]),
        .CS_IO0(cs_o[0][2]), .CS_IO1(cs_o[0][3]), .READY(ready[0]),
        .BUS_ERR(bus_err[0])
    );

    bus_cycle_frontend #(.WAIT_STATES(3), .TIMEOUT_CYCLES(8)) u_dut3 (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR),
        .AD(AD), .A(A), .ADDR_Q(addr_q[1]), .IOM_Q(iom_q[1]),
        .ALE_Q(ale_q[1]), .CS_MEM0(cs_o[1][0]), .CS_MEM1(cs_o[1][1]),
        .CS_IO0(cs_o[1][2]), .CS_IO1(cs_o[1][3]), .READY(ready[1]),
        .BUS_ERR(bus_err[1])
    );

    // ---------------- model ----------------
    localparam int P_IDLE = 0, P_LATCHED = 1, P_ARMED = 2;
    localparam int P_WAITING = 3, P_DONE = 4;
    localparam int TO_LIMIT = 8;

    int               ws [2] = '{1, 3};
    int               ph [2];
    int               wleft [2];
    int               tcount [2];
    logic [1:0][19:0] m_addr;
    logic [1:0]       m_iom, m_ale, m_rdy, m_err;
    logic [1:0][3:0]  m_cs;

    function automatic logic [3:0] decode(input logic [19:0] ad, input logic io);
        if (!io) return (ad < 20'h80000) ? 4'b0001 : 4'b0010;
        if (ad >= 20'h10000) return 4'b0000;
        if (ad / 16 == 20'h0000F) return 4'b0100;
        if (ad / 16 == 20'h0000E) return 4'b1000;
        return 4'b0000;
    endfunction

    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (RESET) begin
                ph[i] = P_IDLE; m_addr[i] = '0; m_iom[i] = 0; m_ale[i] = 0;
                m_cs[i] = '0; m_rdy[i] = 1; m_err[i] = 0;
                wleft[i] = 0; tcount[i] = 0;
            end else begin
                m_ale[i] = 0;
                m_err[i] = 0;
                if (ph[i] == P_IDLE && ALE) begin
                    m_addr[i] = {A, AD}; m_iom[i] = IOM; m_ale[i] = 1;
                    m_cs[i] = decode({A, AD}, IOM); ph[i] = P_LATCHED;
                end else if (ph[i] == P_LATCHED) begin
                    ph[i] = P_ARMED; tcount[i] = 0;
                end else if (ph[i] == P_ARMED) begin
                    if (!RD || !WR) begin
                        if (ws[i] == 0 || m_cs[i] == 0) ph[i] = P_DONE;
                        else begin
                            wleft[i] = ws[i]; m_rdy[i] = 0; ph[i] = P_WAITING;
                        end
                    end else if (ALE) begin
                        m_addr[i] = {A, AD}; m_iom[i] = IOM; m_ale[i] = 1;
                        m_cs[i] = decode({A, AD}, IOM); ph[i] = P_LATCHED;
                    end else begin
`ifdef BUS_TIMEOUT_EN
                        tcount[i]++;
                        if (tcount[i] == TO_LIMIT) begin
                            m_cs[i] = '0; m_err[i] = 1; ph[i] = P_IDLE;
                        end
`endif
                    end
                end else if (ph[i] == P_WAITING) begin
                    wleft[i]--;
                    if (wleft[i] == 0) begin
                        m_rdy[i] = 1; ph[i] = P_DONE;
                    end
                end else if (ph[i] == P_DONE && RD && WR) begin
                    m_cs[i] = '0; ph[i] = P_IDLE;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("addr_q[%0d]", i), 32'(addr_q[i]), 32'(m_addr[i]));
                chk($sformatf("iom_q[%0d]", i), 32'(iom_q[i]), 32'(m_iom[i]));
                chk($sformatf("ale_q[%0d]", i), 32'(ale_q[i]), 32'(m_ale[i]));
                chk($sformatf("cs[%0d]", i), 32'(cs_o[i]), 32'(m_cs[i]));
                chk($sformatf("ready[%0d]", i), 32'(ready[i]), 32'(m_rdy[i]));
                chk($sformatf("bus_err[%0d]", i), 32'(bus_err[i]), 32'(m_err[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start_cycle(input logic io, input logic [11:0] hi,
                               input logic [7:0] lo);
        IOM = io; A = hi; AD = lo; ALE = 1;
        cyc(1);
        ALE = 0;
    endtask

    int lo1, lo3, hit;

    initial begin
        RESET = 1; ALE = 0; IOM = 0; RD = 1; WR = 1; AD = '0; A = '0;
        cyc(2);
        started = 1;
        chk("reset_addr", 32'(addr_q[0]), 32'h0);
        chk("reset_ready", 32'(ready), 32'h3);
        chk("reset_cs", 32'(cs_o), 32'h0);
        RESET = 0;
        cyc(1);

        // memory read at 81234
        start_cycle(1'b0, 12'h812, 8'h34);
        chk("mem_addr", 32'(addr_q[0]), 32'h81234);
        chk("mem_ale", 32'(ale_q), 32'h3);
        chk("mem_cs", 32'(cs_o[0]), 32'b0010);
        cyc(1);
        RD = 0;
        lo1 = 0; lo3 = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            if (!ready[0]) lo1++;
            if (!ready[1]) lo3++;
        end
        chk("mem_ready_low_ws1", 32'(lo1), 32'd1);
        chk("mem_ready_low_ws3", 32'(lo3), 32'd3);
        chk("mem_cs_held", 32'(cs_o[0]), 32'b0010);
        RD = 1;
        cyc(1);
        chk("mem_cs_drop", 32'(cs_o[0]), 32'b0000);
        cyc(1);

        // IO write at 00E5
        start_cycle(1'b1, 12'h000, 8'hE5);
        chk("io_cs", 32'(cs_o[0]), 32'b1000);
        chk("io_iom", 32'(iom_q[0]), 32'h1);
        cyc(1);
        WR = 0;
        lo1 = 0; lo3 = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            if (!ready[0]) lo1++;
            if (!ready[1]) lo3++;
        end
        chk("io_ready_low_ws1", 32'(lo1), 32'd1);
        chk("io_ready_low_ws3", 32'(lo3), 32'd3);
        WR = 1;
        cyc(2);

        // unmapped IO at 0300
        start_cycle(1'b1, 12'h003, 8'h00);
        chk("unmapped_cs", 32'(cs_o), 32'h0);
        cyc(1);
        RD = 0;
        lo3 = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            if (!ready[1]) lo3++;
        end
        chk("unmapped_ready", 32'(lo3), 32'd0);
        RD = 1;
        cyc(2);

        // abort: second ALE while armed
        start_cycle(1'b0, 12'h812, 8'h34);
        cyc(2);
        start_cycle(1'b0, 12'h000, 8'h10);
        chk("abort_addr", 32'(addr_q[0]), 32'h00010);
        chk("abort_ale", 32'(ale_q[0]), 32'h1);
        chk("abort_cs", 32'(cs_o[0]), 32'b0001);
        cyc(1);
        RD = 0;
        cyc(5);
        RD = 1;
        cyc(2);

        // watchdog behaviour
        start_cycle(1'b0, 12'h100, 8'h00);
        cyc(1);
        hit = 0;
`ifdef BUS_TIMEOUT_EN
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (bus_err[0] && hit == 0) begin
                hit = k;
                chk("timeout_cs", 32'(cs_o[0]), 32'h0);
            end
        end
        chk("timeout_cycles", 32'(hit), 32'd8);
`else
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            if (bus_err[0]) hit++;
        end
        chk("no_timeout_err", 32'(hit), 32'd0);
        chk("no_timeout_cs", 32'(cs_o[0]), 32'b0001);
        RD = 0;
        cyc(5);
        RD = 1;
        cyc(2);
`endif

        // reset in the middle of a wait-state run
        start_cycle(1'b0, 12'h812, 8'h34);
        cyc(1);
        RD = 0;
        cyc(1);
        chk("wait_ready_low", 32'(ready[1]), 32'h0);
        RESET = 1;
        cyc(1);
        chk("rst_ready", 32'(ready[1]), 32'h1);
        chk("rst_cs", 32'(cs_o[1]), 32'h0);
        chk("rst_addr", 32'(addr_q[1]), 32'h0);
        RESET = 0; RD = 1;
        cyc(2);
        start_cycle(1'b0, 12'h000, 8'h20);
        chk("post_rst_latch", 32'(addr_q[1]), 32'h00020);
        cyc(3);

        started = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
